// File: rtl/sync_fifo_wr_arbiter_if.sv
// Write-side bus between NUM_REQ producers, the round-robin arbiter and the
// FIFO write port. The lock vector exists only when FIFO_ARB_LOCK_EN is defined.
//
// Handshake: a producer raises req[i] with valid req_data slice i and holds both
// stable until gnt[i] is seen high at a rising edge; that same edge writes the
// word into the FIFO (fifo_w_en/fifo_wdata). fifo_full acts as the ready side:
// while it is high no grant is issued and every producer stalls.
interface sync_fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
`ifdef FIFO_ARB_LOCK_EN
   logic [NUM_REQ-1:0]            lock;
`endif
   logic [NUM_REQ-1:0]            gnt;
   logic                          fifo_full;
   logic                          fifo_w_en;
   logic [DATA_WIDTH-1:0]         fifo_wdata;

`ifdef FIFO_ARB_LOCK_EN
   // Arbiter side
   modport master (
      input  req, req_data, lock, fifo_full,
      output gnt, fifo_w_en, fifo_wdata
   );
   // Producer / FIFO side
   modport slave (
      output req, req_data, lock, fifo_full,
      input  gnt, fifo_w_en, fifo_wdata
   );
`else
   // Arbiter side
   modport master (
      input  req, req_data, fifo_full,
      output gnt, fifo_w_en, fifo_wdata
   );
   // Producer / FIFO side
   modport slave (
      output req, req_data, fifo_full,
      input  gnt, fifo_w_en, fifo_wdata
   );
`endif
endinterface

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one synchronous FIFO write port among
// NUM_REQ producers. Grant is combinational from a registered rotating pointer.
// Optional burst lock (ARB/LOCKED FSM) is built when FIFO_ARB_LOCK_EN is defined;
// without it the block is pure round-robin and state_o is constantly ARB.
module sync_fifo_wr_arbiter #(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 8,
   localparam int IDW        = $clog2(NUM_REQ)
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   sync_fifo_wr_arbiter_if.master   bus,
   output logic [IDW-1:0]           last_gnt_id_o,
   output logic [15:0]              wr_count_o,
   output logic [IDW-1:0]           rr_ptr_o,
   output logic                     state_o
);

   localparam int PW = IDW + 1;

   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t                 state_q;
   logic [NUM_REQ-1:0]     req_eff;
   logic                   gnt_found;
   logic [IDW-1:0]         gnt_idx;
   logic [NUM_REQ-1:0]     gnt;
   logic [DATA_WIDTH-1:0]  wdata;
   logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]         last_gnt_id_q, last_gnt_id_d;
   logic [15:0]            wr_count_q, wr_count_d;

`ifdef FIFO_ARB_LOCK_EN
   state_t                 state_d;
   logic [IDW-1:0]         owner_q, owner_d;
   logic                   owner_hold;

   // FSM state register: burst owner survives until it drops req or lock
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_ARB;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // FSM next state: a grant decides the state; a full FIFO freezes it
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if (gnt_found) begin
         if (bus.lock[gnt_idx]) begin
            state_d = ST_LOCKED;
            owner_d = gnt_idx;
         end else begin
            state_d = ST_ARB;
         end
      end else if ((state_q == ST_LOCKED) && !owner_hold && !bus.fifo_full) begin
         state_d = ST_ARB;
      end
   end

   // FSM output: while the owner still holds req and lock, mask everyone else
   always_comb begin
      owner_hold = (state_q == ST_LOCKED) && bus.req[owner_q] && bus.lock[owner_q];
      req_eff    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_eff[i] = bus.req[i] && (!owner_hold || (owner_q == IDW'(i)));
      end
   end
`else
   assign state_q = ST_ARB;
   assign req_eff = bus.req;
`endif

   // Search upward from rr_ptr with wrap; no grant while full or in reset
   always_comb begin
      logic [PW-1:0] pos;
      pos       = '0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         pos = {1'b0, rr_ptr_q} + PW'(off);
         if (pos >= PW'(NUM_REQ)) begin
            pos = pos - PW'(NUM_REQ);
         end
         if (!gnt_found && req_eff[pos[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = pos[IDW-1:0];
         end
      end
      if (bus.fifo_full || !rst_n_i) begin
         gnt_found = 1'b0;
      end
   end

   // One-hot grant and write-data mux; data reads zero when nothing is granted
   always_comb begin
      gnt   = '0;
      wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_found && (gnt_idx == IDW'(i))) begin
            gnt[i] = 1'b1;
            wdata  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Pointer moves past the winner; id and count update only on a grant
   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      last_gnt_id_d = last_gnt_id_q;
      wr_count_d    = wr_count_q;
      if (gnt_found) begin
         rr_ptr_d      = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
         last_gnt_id_d = gnt_idx;
         wr_count_d    = wr_count_q + 16'd1;
      end
   end

   // Arbiter bookkeeping registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rr_ptr_q      <= '0;
         last_gnt_id_q <= '0;
         wr_count_q    <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         last_gnt_id_q <= last_gnt_id_d;
         wr_count_q    <= wr_count_d;
      end
   end

   assign bus.gnt        = gnt;
   assign bus.fifo_w_en  = gnt_found;
   assign bus.fifo_wdata = wdata;

   assign last_gnt_id_o  = last_gnt_id_q;
   assign wr_count_o     = wr_count_q;
   assign rr_ptr_o       = rr_ptr_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Bench for sync_fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8). Burst-lock steps are
// compiled in only when FIFO_ARB_LOCK_EN is defined.
module tb_sync_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int W  = NR + DW;

   // Clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sync_fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   logic [1:0]  last_gnt_id;
   logic [15:0] wr_count;
   logic [1:0]  rr_ptr;
   logic        state;

   sync_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .bus          (bus),
      .last_gnt_id_o(last_gnt_id),
      .wr_count_o   (wr_count),
      .rr_ptr_o     (rr_ptr),
      .state_o      (state)
   );

   // Scoreboard: expected {gnt, wdata} per cycle
   logic [W-1:0]  exp_q[$];
   logic [DW-1:0] words[NR];
   int            errors = 0;
   int            checks = 0;
   logic [1:0]    m_rr;
   logic [1:0]    m_last;
   logic [15:0]   m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_words();
      for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = words[i];
   endtask

   function automatic logic [NR-1:0] ref_grant(input logic [NR-1:0] r, input logic f,
                                               input logic [1:0] p);
      logic [NR-1:0] g;
      g = '0;
      if (!f) begin
         for (int o = 0; o < NR; o++) begin
            int j;
            j = (int'(p) + o) % NR;
            if (r[j] && (g == '0)) g[j] = 1'b1;
         end
      end
      return g;
   endfunction

   // Driver: one cycle of stimulus with its expected grant
   task automatic step(input logic [NR-1:0] r, input logic f, input logic [NR-1:0] eg,
                       input string tag);
      logic [W-1:0] e;
      int k;
      bus.req       = r;
      bus.fifo_full = f;
      k = -1;
      for (int i = 0; i < NR; i++) if (eg[i]) k = i;
      if (k >= 0) e = {eg, words[k]};
      else        e = {eg, {DW{1'b0}}};
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      check({tag, "_gnt"},   32'(bus.gnt),        32'(e[W-1:DW]));
      check({tag, "_wen"},   32'(bus.fifo_w_en),  32'(|e[W-1:DW]));
      check({tag, "_wdata"}, 32'(bus.fifo_wdata), 32'(e[DW-1:0]));
      if (k >= 0) begin
         m_cnt  = m_cnt + 16'd1;
         m_last = 2'(k);
         m_rr   = (k == NR - 1) ? 2'd0 : 2'(k + 1);
      end
      @(posedge clk);
      #1;
      check({tag, "_cnt"},  32'(wr_count),    32'(m_cnt));
      check({tag, "_last"}, 32'(last_gnt_id), 32'(m_last));
      check({tag, "_ptr"},  32'(rr_ptr),      32'(m_rr));
   endtask

   // Async reset asserted off-edge; outputs must read zero while it is low
   task automatic apply_reset(input logic [NR-1:0] r);
      logic [W-1:0] e;
      bus.req       = r;
      bus.fifo_full = 1'b0;
      rst_n         = 1'b0;
      #1;
      exp_q.push_back('0);
      e = exp_q.pop_front();
      check("rst_gnt",   32'(bus.gnt),        32'(e[W-1:DW]));
      check("rst_wen",   32'(bus.fifo_w_en),  32'(|e[W-1:DW]));
      check("rst_wdata", 32'(bus.fifo_wdata), 32'(e[DW-1:0]));
      check("rst_cnt",   32'(wr_count),       32'd0);
      check("rst_last",  32'(last_gnt_id),    32'd0);
      check("rst_ptr",   32'(rr_ptr),         32'd0);
      check("rst_state", 32'(state),          32'd0);
      m_cnt  = '0;
      m_last = '0;
      m_rr   = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [NR-1:0] r;
      logic          f;
      rst_n         = 1'b1;
      bus.req       = '0;
      bus.fifo_full = 1'b0;
`ifdef FIFO_ARB_LOCK_EN
      bus.lock      = '0;
`endif
      for (int i = 0; i < NR; i++) words[i] = 8'hA0 + 8'(i);
      load_words();
      m_cnt  = '0;
      m_last = '0;
      m_rr   = '0;
      #2;

      apply_reset(4'b1111);

      // All four requesting: strict rotation
      for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 4'(1 << (i % 4)), "rot");
      check("rot_total", 32'(wr_count), 32'd8);

      // Wrap-around with rr_ptr = 2
      step(4'b0010, 1'b0, 4'b0010, "pre");
      step(4'b1010, 1'b0, 4'b1000, "wrap_a");
      check("wrap_a_id", 32'(last_gnt_id), 32'd3);
      step(4'b1010, 1'b0, 4'b0010, "wrap_b");
      check("wrap_b_id", 32'(last_gnt_id), 32'd1);

      // FIFO full stalls everything
      for (int i = 0; i < 3; i++) step(4'b0100, 1'b1, 4'b0000, "full");
      check("full_cnt", 32'(wr_count), 32'd11);
      check("full_ptr", 32'(rr_ptr),   32'd2);
      step(4'b0100, 1'b0, 4'b0100, "full_rel");

      // Idle, then a single requester every cycle
      step(4'b0000, 1'b0, 4'b0000, "idle");
      for (int i = 0; i < 3; i++) step(4'b1000, 1'b0, 4'b1000, "single");

      // Random requests, data and full
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NR; i++) words[i] = 8'($urandom_range(0, 255));
         load_words();
         r = 4'($urandom_range(0, 15));
         f = ($urandom_range(0, 3) == 0);
         step(r, f, ref_grant(r, f, m_rr), "rand");
      end

      // Mid-run reset, then first grant right after release
      apply_reset(4'b1111);
      step(4'b1111, 1'b0, 4'b0001, "post_rst");

      // Write counter wraps 0xFFFF -> 0x0000
      apply_reset(4'b0001);
      repeat (65535) @(posedge clk);
      #1;
      check("cnt_ffff", 32'(wr_count), 32'h0000FFFF);
      m_cnt  = 16'hFFFF;
      m_last = 2'd0;
      m_rr   = 2'd1;
      step(4'b0001, 1'b0, 4'b0001, "cnt_wrap");
      check("cnt_zero", 32'(wr_count), 32'd0);

`ifdef FIFO_ARB_LOCK_EN
      // Burst lock on producer 1
      apply_reset(4'b0000);
      step(4'b0001, 1'b0, 4'b0001, "lk_pre");
      bus.lock = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         step(4'b1111, 1'b0, 4'b0010, "lk_own");
         check("lk_own_state", 32'(state), 32'd1);
      end
      step(4'b1111, 1'b1, 4'b0000, "lk_full");
      check("lk_full_state", 32'(state), 32'd1);
      bus.lock = 4'b0000;
      step(4'b1111, 1'b0, 4'b0100, "lk_rel");
      check("lk_rel_state", 32'(state), 32'd0);
      bus.lock = 4'b1000;
      step(4'b1111, 1'b0, 4'b1000, "lk3");
      check("lk3_state", 32'(state), 32'd1);
      apply_reset(4'b1111);
      bus.lock = 4'b0000;
      step(4'b1111, 1'b0, 4'b0001, "lk_post_rst");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sync_fifo_wr_arbiter.md
# sync_fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO's write port among NUM_REQ producers. Each cycle it selects at most one requesting producer, forwards that producer's data to the FIFO write port and returns a one-cycle grant. It sits directly in front of the team's synchronous FIFO and drives its `w_en`/`data_in`, consuming its `full` flag. Fairness comes from a registered rotating priority pointer, with an optional lock mode for multi-beat bursts.

## Interface
- `NUM_REQ`, 4: number of producers, legal range 2..16 (need not be a power of two).
- `DATA_WIDTH`, 8: FIFO word width.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-producer write request.
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer i's word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `lock`  in  NUM_REQ  burst-lock request; present only when FIFO_ARB_LOCK_EN is defined.
- `gnt`  out  NUM_REQ  one-hot grant; producer i's word is written this cycle.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_w_en`  out  1  FIFO write enable.
- `fifo_wdata`  out  DATA_WIDTH  FIFO write data.
- `last_gnt_id`  out  $clog2(NUM_REQ)  index of the most recent granted producer (registered).
- `wr_count`  out  16  total granted writes since reset; wraps 0xFFFF -> 0x0000.

## Operation
- Handshake:
  - A producer raises `req` with valid `req_data`, then holds both stable until it sees `gnt[i]` high at a rising edge.
  - It may drop `req` on the cycle after the grant, or keep it high to request the next word.
- Grant, combinational in the current cycle:
  - If `fifo_full` is 0 and any `req` is 1, `gnt` is the first set bit of `req` searching upward from `rr_ptr`, wrapping past NUM_REQ-1 to 0.
  - Otherwise `gnt` is all zero.
- `fifo_w_en` = OR of `gnt`. `fifo_wdata` = the granted producer's word; when `fifo_w_en` is 0 it is all zeros.
- Pointer: after a grant to index k, `rr_ptr` <= k+1, or 0 if k = NUM_REQ-1. With no grant, `rr_ptr` holds.
- `last_gnt_id` <= k on each grant; otherwise it holds.
- `wr_count` increments by 1 on each cycle with `fifo_w_en` = 1.
- States: ARB (normal rotation) and LOCKED (only with FIFO_ARB_LOCK_EN).
  - ARB -> LOCKED: a grant to k with `lock[k]` = 1. The owner register stores k.
  - LOCKED -> ARB: owner samples `req` = 0 or `lock` = 0. That cycle is arbitrated normally from `rr_ptr`; the owner is not excluded.
- Boundaries:
  - `fifo_full` = 1: no grant, `rr_ptr` and state unchanged, producers stall.
  - Single requester: granted every non-full cycle.
  - All requesters active: strict rotation 0,1,2,...,NUM_REQ-1,0.
  - No combinational path exists from `gnt` back to `req`.

## Timing
- Grant latency is zero cycles. The FIFO captures `fifo_wdata` at the same edge at which the producer sees `gnt`.
- Throughput is one word per cycle while the FIFO is not full.
- Reset (async assert, any time, including mid-burst or while LOCKED):
  - `rr_ptr`=0, state=ARB, `last_gnt_id`=0, `wr_count`=0.
  - `gnt`, `fifo_w_en`, `fifo_wdata` read 0 while `rst_n` is 0, regardless of `req`.
- Deassertion takes effect at the next rising edge. The first grant is possible in the first cycle with `rst_n` = 1.

## Configuration
- `FIFO_ARB_LOCK_EN` defined:
  - `lock` port exists; the LOCKED state is implemented.
  - While LOCKED, only the owner can be granted. Other requests are masked even if the owner is idle-stalled on `fifo_full`.
  - `rr_ptr` still advances past the owner on each owner grant.
- Not defined: no `lock` port; the block is pure round-robin, with state permanently ARB.

## Test plan
- Reset: `rst_n`=0 with `req`=4'b1111 -> `gnt`=0, `fifo_w_en`=0, `wr_count`=0; release -> first cycle `gnt`=4'b0001.
- All four requesting for 8 cycles, `fifo_full`=0 -> `gnt` sequence 0001,0010,0100,1000,0001,... ; `wr_count`=8; each `fifo_wdata` equals the granted producer's word (e.g. 0xA0+i).
- `req`=4'b1010 with `rr_ptr`=2 -> grant 1000, then 0010 (wrap-around); `last_gnt_id`=3 then 1.
- `fifo_full`=1 for 3 cycles with `req`=4'b0100 -> no grants, `wr_count` and `rr_ptr` unchanged; full drops -> `gnt`=4'b0100 in that cycle.
- Force `wr_count`=0xFFFF, then one grant -> `wr_count`=0x0000.
- FIFO_ARB_LOCK_EN, producer 1 with `lock`=1, `req`=4'b1111 for 4 cycles -> `gnt`=0010 four times; `lock` drops -> next `gnt`=0100; async reset while LOCKED -> state ARB, `rr_ptr`=0.
